// File: rtl/vend_ctrl_pkg.sv
// rtl/vend_ctrl_pkg.sv - coin codes and FSM state encodings for the vending controller
package vend_ctrl_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_CB   = 2'b01,
        COIN_CA   = 2'b10,
        COIN_BAD  = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_VEND   = 2'b01,
        ST_CHANGE = 2'b10,
        ST_REFUND = 2'b11
    } state_e;

endpackage

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending controller: coin credit, item release handshake, change and refund
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int PRICE  = 5,
    parameter int COIN_A = 2,
    parameter int COIN_B = 5,
    parameter int CRED_W = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        coin,
    input  logic              cancel,
    input  logic              rls_ack,
    output logic              rls,
    output logic [CRED_W-1:0] change,
    output logic              chg_vld,
    output logic              coin_rej,
    output logic [CRED_W-1:0] credit,
    output logic              busy
);

    localparam int MAX_CRED = 2**CRED_W - 1;
    localparam logic [CRED_W:0] VAL_A   = COIN_A[CRED_W:0];
    localparam logic [CRED_W:0] VAL_B   = COIN_B[CRED_W:0];
    localparam logic [CRED_W:0] PRICE_W = PRICE[CRED_W:0];
    localparam logic [CRED_W:0] MAX_W   = MAX_CRED[CRED_W:0];

    state_e              state_q, state_d;
    logic [CRED_W-1:0]   credit_q, credit_d;
    logic [CRED_W-1:0]   change_q, change_d;
    logic                rls_q, rls_d;
    logic                chg_vld_q, chg_vld_d;
    logic                coin_rej_q, coin_rej_d;

    coin_e               coin_c;
    logic [CRED_W:0]     coin_val;
    logic                coin_ok;
    logic [CRED_W:0]     sum;
    logic [CRED_W:0]     surplus;

    assign coin_c = coin_e'(coin);

    always_comb begin
        coin_val = '0;
        coin_ok  = 1'b0;
        case (coin_c)
            COIN_CA: begin coin_val = VAL_A; coin_ok = 1'b1; end
            COIN_CB: begin coin_val = VAL_B; coin_ok = 1'b1; end
            default: begin coin_val = '0;    coin_ok = 1'b0; end
        endcase
        sum     = {1'b0, credit_q} + coin_val;
        surplus = sum - PRICE_W;
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        rls_d      = rls_q;
        change_d   = '0;
        chg_vld_d  = 1'b0;
        coin_rej_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Cancel dominates any coin presented in the same cycle; that coin is returned.
                if (cancel) begin
                    coin_rej_d = (coin_c != COIN_NONE);
                    if (credit_q != '0) begin
                        state_d   = ST_REFUND;
                        change_d  = credit_q;
                        chg_vld_d = 1'b1;
                        credit_d  = '0;
                    end
                end else if (coin_c == COIN_BAD) begin
                    coin_rej_d = 1'b1;
                end else if (coin_ok) begin
                    if (sum > MAX_W) begin
                        coin_rej_d = 1'b1;
                    end else if (sum >= PRICE_W) begin
                        credit_d = surplus[CRED_W-1:0];
                        rls_d    = 1'b1;
                        state_d  = ST_VEND;
                    end else begin
                        credit_d = sum[CRED_W-1:0];
                    end
                end
            end
            ST_VEND: begin
                coin_rej_d = (coin_c != COIN_NONE);
                if (rls_ack) begin
                    rls_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d   = ST_CHANGE;
                        change_d  = credit_q;
                        chg_vld_d = 1'b1;
                        credit_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            // The payout pulse is registered on entry, so these states last exactly one cycle.
            ST_CHANGE, ST_REFUND: begin
                coin_rej_d = (coin_c != COIN_NONE);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            rls_q      <= 1'b0;
            chg_vld_q  <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            rls_q      <= rls_d;
            chg_vld_q  <= chg_vld_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign rls      = rls_q;
    assign change   = change_q;
    assign chg_vld  = chg_vld_q;
    assign coin_rej = coin_rej_q;
    assign credit   = credit_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl with a payout scoreboard
module tb_vend_ctrl;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_A    = 2'b10;
    localparam logic [1:0] C_B    = 2'b01;
    localparam logic [1:0] C_BAD  = 2'b11;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] a_coin = '0, b_coin = '0, c_coin = '0;
    logic       a_cancel = 0, b_cancel = 0, c_cancel = 0;
    logic       a_ack = 0, b_ack = 0, c_ack = 0;
    logic       a_rls, b_rls, c_rls;
    logic [3:0] a_change, b_change, c_change;
    logic       a_chg_vld, b_chg_vld, c_chg_vld;
    logic       a_coin_rej, b_coin_rej, c_coin_rej;
    logic [3:0] a_credit, b_credit, c_credit;
    logic       a_busy, b_busy, c_busy;

    vend_ctrl #(.PRICE(5), .COIN_A(2), .COIN_B(5), .CRED_W(4)) u_dut (
        .clk(clk), .nrst(nrst), .coin(a_coin), .cancel(a_cancel), .rls_ack(a_ack),
        .rls(a_rls), .change(a_change), .chg_vld(a_chg_vld), .coin_rej(a_coin_rej),
        .credit(a_credit), .busy(a_busy)
    );

    vend_ctrl #(.PRICE(9), .COIN_A(2), .COIN_B(5), .CRED_W(4)) u_dut9 (
        .clk(clk), .nrst(nrst), .coin(b_coin), .cancel(b_cancel), .rls_ack(b_ack),
        .rls(b_rls), .change(b_change), .chg_vld(b_chg_vld), .coin_rej(b_coin_rej),
        .credit(b_credit), .busy(b_busy)
    );

    vend_ctrl #(.PRICE(15), .COIN_A(2), .COIN_B(5), .CRED_W(4)) u_dut15 (
        .clk(clk), .nrst(nrst), .coin(c_coin), .cancel(c_cancel), .rls_ack(c_ack),
        .rls(c_rls), .change(c_change), .chg_vld(c_chg_vld), .coin_rej(c_coin_rej),
        .credit(c_credit), .busy(c_busy)
    );

    int checks = 0;
    int errors = 0;
    int exp_chg_q[$];
    int exp_rej = 0;
    int rej_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        a_coin = C_NONE; a_cancel = 0; a_ack = 0;
        b_coin = C_NONE; b_cancel = 0; b_ack = 0;
        c_coin = C_NONE; c_cancel = 0; c_ack = 0;
    endtask

    // Every payout on the main instance must match the oldest expected amount.
    always @(negedge clk) begin
        if (!nrst) begin
            if (a_chg_vld) begin
                if (exp_chg_q.size() > 0) check("chg_amt", a_change, exp_chg_q.pop_front());
                else check("chg_unexpected", 1, 0);
            end else if (a_change != 4'd0) begin
                check("chg_idle_zero", a_change, 0);
            end
            if (a_coin_rej) rej_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_rls", a_rls, 0);
        check("rst_credit", a_credit, 0);
        check("rst_busy", a_busy, 0);
        check("rst_chg_vld", a_chg_vld, 0);
        check("rst_coin_rej", a_coin_rej, 0);
        check("rst_change", a_change, 0);
        nrst = 0;
        tick();

        // 2+2+2 -> vend with surplus 1
        a_coin = C_A; tick(); check("t2_cred2", a_credit, 2);
        a_coin = C_A; tick(); check("t2_cred4", a_credit, 4); check("t2_norls", a_rls, 0);
        a_coin = C_A; exp_chg_q.push_back(1); tick();
        check("t2_rls", a_rls, 1); check("t2_cred1", a_credit, 1); check("t2_busy", a_busy, 1);
        tick(); check("t2_rls_hold", a_rls, 1);
        a_ack = 1; tick();
        check("t2_rls_drop", a_rls, 0); check("t2_chg_vld", a_chg_vld, 1); check("t2_cred0", a_credit, 0);
        tick(); check("t2_idle", a_busy, 0); check("t2_pulse_end", a_chg_vld, 0);

        // single COIN_B, then second coin rejected while busy
        a_coin = C_B; tick(); check("t3_rls", a_rls, 1); check("t3_cred", a_credit, 0);
        a_coin = C_B; exp_rej++; tick();
        check("t3_rej", a_coin_rej, 1); check("t3_cred_busy", a_credit, 0); check("t3_rls_hold", a_rls, 1);
        a_ack = 1; tick(); check("t3_rls_drop", a_rls, 0); check("t3_nochg", a_chg_vld, 0);
        check("t3_idle", a_busy, 0);

        // ack outside VEND ignored
        a_ack = 1; tick(); check("ack_idle_busy", a_busy, 0); check("ack_idle_rls", a_rls, 0);

        // 2+2 then cancel -> refund 4; cancel at zero credit -> nothing
        a_coin = C_A; tick();
        a_coin = C_A; tick(); check("t4_cred4", a_credit, 4);
        a_cancel = 1; exp_chg_q.push_back(4); tick();
        check("t4_vld", a_chg_vld, 1); check("t4_rls", a_rls, 0); check("t4_cred0", a_credit, 0);
        check("t4_busy", a_busy, 1);
        tick(); check("t4_idle", a_busy, 0);
        a_cancel = 1; tick(); check("t4_zero_vld", a_chg_vld, 0); check("t4_zero_busy", a_busy, 0);

        // invalid coin, then coin + cancel in one cycle
        a_coin = C_BAD; exp_rej++; tick(); check("t5_bad_rej", a_coin_rej, 1); check("t5_bad_cred", a_credit, 0);
        a_coin = C_A; tick(); check("t5_cred2", a_credit, 2);
        a_coin = C_BAD; exp_rej++; tick(); check("t5_bad2_cred", a_credit, 2);
        a_coin = C_A; a_cancel = 1; exp_rej++; exp_chg_q.push_back(2); tick();
        check("t5_both_rej", a_coin_rej, 1); check("t5_both_vld", a_chg_vld, 1); check("t5_both_cred", a_credit, 0);
        tick();

        // delayed ack: rls held for five cycles
        a_coin = C_B; tick();
        for (int i = 0; i < 5; i++) begin
            check("t6_rls_held", a_rls, 1);
            tick();
        end
        a_ack = 1; tick(); check("t6_rls_drop", a_rls, 0); check("t6_idle", a_busy, 0);

        // asynchronous reset mid-VEND discards item and surplus
        a_coin = C_A; tick();
        a_coin = C_A; tick();
        a_coin = C_A; tick(); check("t1_in_vend", a_rls, 1);
        #2 nrst = 1;
        #1;
        check("t1_rls", a_rls, 0); check("t1_cred", a_credit, 0); check("t1_busy", a_busy, 0);
        #3 nrst = 0;
        tick(); check("t1_after_busy", a_busy, 0); check("t1_after_vld", a_chg_vld, 0);

        // PRICE=9: 5+5 -> vend with change 1
        b_coin = C_B; tick(); check("p9_cred5", b_credit, 5);
        b_coin = C_B; tick(); check("p9_rls", b_rls, 1); check("p9_cred1", b_credit, 1);
        b_ack = 1; tick(); check("p9_vld", b_chg_vld, 1); check("p9_change", b_change, 1);
        tick(); check("p9_idle", b_busy, 0);

        // PRICE=15: credit at 14 rejects coins that would pass MAX_CRED
        for (int i = 0; i < 7; i++) begin
            c_coin = C_A; tick();
        end
        check("p15_cred14", c_credit, 14);
        c_coin = C_A; tick(); check("p15_ovf_a_rej", c_coin_rej, 1); check("p15_ovf_a_cred", c_credit, 14);
        c_coin = C_B; tick(); check("p15_ovf_b_rej", c_coin_rej, 1); check("p15_ovf_b_cred", c_credit, 14);
        c_cancel = 1; tick(); check("p15_refund_vld", c_chg_vld, 1); check("p15_refund_amt", c_change, 14);
        tick();
        c_coin = C_B; tick();
        c_coin = C_B; tick(); check("p15_cred10", c_credit, 10);
        c_coin = C_B; tick(); check("p15_max_rls", c_rls, 1); check("p15_max_cred", c_credit, 0);
        c_ack = 1; tick(); check("p15_max_nochg", c_chg_vld, 0); check("p15_max_idle", c_busy, 0);

        repeat (2) tick();
        check("sb_pending", exp_chg_q.size(), 0);
        check("rej_count", rej_seen, exp_rej);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
